// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle RV32I control unit sequencing fetch, decode, execute, memory and writeback
module multicycle_ctrl_fsm #(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit EN_LUI   = 1'b1,
    parameter bit EN_TRAP  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_o
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
    } ctrl_t;

    // Moore control word for a state; handshake-dependent terms are added at the outputs
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.done      = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   illegal_q, illegal_d;
    logic   rdy, lui_ok, op_legal;

    // Handshake view, opcode legality and the next-state/next-output computation
    always_comb begin
        rdy      = MEM_WAIT ? mem_ready : 1'b1;
        lui_ok   = EN_LUI && op == OP_LUI;
        op_legal = op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                   op == OP_JAL || op == OP_BEQ || lui_ok;
        state_d  = state_q;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = lui_ok ? S_LUI : EN_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_LUI, S_JAL: state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_q == S_DECODE && !op_legal);
        ctrl_d    = ctrl_of(state_d);
    end

    // State, registered control word and sticky illegal flag; reset wins over every transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_of(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // Immediate format straight from the opcode so it is ready during DECODE
    always_comb begin
        ImmSrc = op == OP_SW  ? 3'b001 :
                 op == OP_BEQ ? 3'b010 :
                 op == OP_JAL ? 3'b011 :
                 lui_ok       ? 3'b100 : 3'b000;
    end

    // Outputs: registered Moore bits plus the fetch/store handshake and the illegal-as-nop retire
    always_comb begin
        mem_req    = ctrl_q.mem_req;
        IRWrite    = state_q == S_FETCH && rdy;
        PCUpdate   = ctrl_q.pc_update | IRWrite;
        Branch     = ctrl_q.branch;
        RegWrite   = ctrl_q.reg_write;
        MemWrite   = ctrl_q.mem_write;
        AdrSrc     = ctrl_q.adr_src;
        ResultSrc  = ctrl_q.result_src;
        ALUSrcA    = ctrl_q.alu_src_a;
        ALUSrcB    = ctrl_q.alu_src_b;
        ALUOp      = ctrl_q.alu_op;
        illegal    = illegal_q;
        instr_done = ctrl_q.done | (state_q == S_MEMWRITE && rdy) |
                     (state_q == S_DECODE && !op_legal && !EN_TRAP);
        state_o    = state_q;
    end
endmodule
